// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the output-writer FSM state type.
package cnn_pkg;
  localparam int RES_W      = 34;
  localparam int OUT_W      = 16;
  localparam int LANES      = 4;
  localparam int ADDR_W     = 8;
  localparam int FRAC_SHIFT = 8;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} wr_state_t;
endpackage

// File: rtl/ofm_quant.sv
// Requantizer: arithmetic shift, saturate to Q_W signed bits.
// With OFM_RELU_EN defined, negative results are clamped to zero after saturation.
module ofm_quant #(
  parameter int IN_W  = 34,
  parameter int Q_W   = 16,
  parameter int SHIFT = 8
) (
  input  logic [IN_W-1:0] din,
  output logic [Q_W-1:0]  q
);
  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((64'sd1 <<< (Q_W-1)) - 64'sd1);
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  logic signed [IN_W-1:0] shifted;
  logic [Q_W-1:0]         sat;

  assign shifted = $signed(din) >>> SHIFT;

  always_comb begin
    if (shifted > MAX_V)      sat = {1'b0, {(Q_W-1){1'b1}}};
    else if (shifted < MIN_V) sat = {1'b1, {(Q_W-1){1'b0}}};
    else                      sat = shifted[Q_W-1:0];
  end

`ifdef OFM_RELU_EN
  assign q = sat[Q_W-1] ? '0 : sat;
`else
  assign q = sat;
`endif
endmodule

// File: rtl/ofm_writer.sv
// Output-feature-map writer: quantizes result beats, packs LANES per word, writes BRAM.
// Optional OFM_RELU_EN (in ofm_quant) fuses ReLU into writeback.
module ofm_writer
  import cnn_pkg::*;
#(
  parameter int                RES_W      = cnn_pkg::RES_W,
  parameter int                OUT_W      = cnn_pkg::OUT_W,
  parameter int                LANES      = cnn_pkg::LANES,
  parameter int                ADDR_W     = cnn_pkg::ADDR_W,
  parameter int                FRAC_SHIFT = cnn_pkg::FRAC_SHIFT,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                NUM_WORDS  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   res_valid,
  input  logic [RES_W-1:0]       res_data,
  output logic                   res_ready,
  output logic                   ofm_en,
  output logic                   ofm_we,
  output logic [ADDR_W-1:0]      ofm_addr,
  output logic [OUT_W*LANES-1:0] ofm_din,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      words_written
);
  localparam int LC_W = (LANES > 1) ? $clog2(LANES) : 1;

  wr_state_t                   state;
  logic [LC_W-1:0]             lane_cnt;
  logic [ADDR_W-1:0]           word_idx;
  logic [LANES-1:0][OUT_W-1:0] pack, pack_nxt;
  logic [OUT_W-1:0]            q;
  logic                        beat;

  ofm_quant #(.IN_W(RES_W), .Q_W(OUT_W), .SHIFT(FRAC_SHIFT)) u_quant (
    .din (res_data),
    .q   (q)
  );

  assign beat = res_valid && res_ready;

  // Word as it will look once the current beat lands; feeds ofm_din on the last lane.
  always_comb begin
    pack_nxt           = pack;
    pack_nxt[lane_cnt] = q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lane_cnt      <= '0;
      word_idx      <= '0;
      pack          <= '0;
      res_ready     <= 1'b0;
      ofm_en        <= 1'b0;
      ofm_we        <= 1'b0;
      ofm_addr      <= '0;
      ofm_din       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state         <= COLLECT;
          res_ready     <= 1'b1;
          busy          <= 1'b1;
          lane_cnt      <= '0;
          word_idx      <= '0;
          words_written <= '0;
          pack          <= '0;
        end
        COLLECT: if (beat) begin
          pack <= pack_nxt;
          if (lane_cnt == LC_W'(LANES-1)) begin
            state     <= WRITE;
            lane_cnt  <= '0;
            res_ready <= 1'b0;
            ofm_en    <= 1'b1;
            ofm_we    <= 1'b1;
            ofm_addr  <= BASE_ADDR + word_idx;
            ofm_din   <= pack_nxt;
          end else begin
            lane_cnt <= lane_cnt + LC_W'(1);
          end
        end
        WRITE: begin
          ofm_en        <= 1'b0;
          ofm_we        <= 1'b0;
          word_idx      <= word_idx + ADDR_W'(1);
          words_written <= words_written + ADDR_W'(1);
          if (word_idx == ADDR_W'(NUM_WORDS-1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state     <= COLLECT;
            res_ready <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ofm_writer.sv
// Self-checking bench for ofm_writer: constant vectors, random frames vs. arithmetic model.
module tb_ofm_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start1 = 1'b0, v1 = 1'b0;
  logic [33:0] d1 = '0;
  logic        r1, en1, we1, busy1, done1;
  logic [7:0]  a1, ww1;
  logic [63:0] o1;

  logic        start2 = 1'b0, v2 = 1'b0;
  logic [33:0] d2 = '0;
  logic        r2, en2, we2, busy2, done2;
  logic [7:0]  a2, ww2;
  logic [63:0] o2;

  ofm_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .res_valid(v1), .res_data(d1),
    .res_ready(r1), .ofm_en(en1), .ofm_we(we1), .ofm_addr(a1), .ofm_din(o1),
    .busy(busy1), .done(done1), .words_written(ww1)
  );

  ofm_writer #(.BASE_ADDR(8'hFE), .NUM_WORDS(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .res_valid(v2), .res_data(d2),
    .res_ready(r2), .ofm_en(en2), .ofm_we(we2), .ofm_addr(a2), .ofm_din(o2),
    .busy(busy2), .done(done2), .words_written(ww2)
  );

  typedef struct { logic [7:0] a; logic [63:0] d; } wr_t;
  typedef struct { logic [3:0][33:0] b; logic [63:0] exp; } vec_t;

  wr_t cap1[$], cap2[$], exp1[$], exp2[$];
  int  done_cnt1 = 0, done_cnt2 = 0, rv1 = 0, rv2 = 0, env1 = 0, env2 = 0;
  int  total = 0, bad = 0;

  // Observe BRAM port and handshake away from the active edge.
  always @(negedge clk) begin
    if (we1) begin cap1.push_back('{a: a1, d: o1}); if (r1) rv1++; end
    if (we2) begin cap2.push_back('{a: a2, d: o2}); if (r2) rv2++; end
    if (en1 != we1) env1++;
    if (en2 != we2) env2++;
    if (done1) done_cnt1++;
    if (done2) done_cnt2++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference requantizer: floor-divide by 256, clip to int16.
  function automatic logic [15:0] qref(input logic [33:0] d);
    longint v;
    v = longint'($signed(d));
    v = v >>> 8;
`ifdef OFM_RELU_EN
    if (v < 0) return 16'h0000;
`endif
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  function automatic logic [63:0] mword(input logic [3:0][33:0] b);
    return {qref(b[3]), qref(b[2]), qref(b[1]), qref(b[0])};
  endfunction

  function automatic logic [33:0] rnd34();
    logic [63:0] t;
    t = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       return 34'(longint'(int'($urandom_range(0, 33554431)) - 16777216));
      1:       return 34'(longint'(int'($urandom_range(0, 2047)) - 1024));
      default: return t[33:0];
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input int u);
    if (u == 0) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic send(input int u, input logic [33:0] d);
    int   n;
    logic acc;
    if (u == 0) begin v1 = 1'b1; d1 = d; end else begin v2 = 1'b1; d2 = d; end
    n = 0; acc = 1'b0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = (u == 0) ? r1 : r2;
      @(posedge clk); #1;
      n++;
    end
    if (u == 0) v1 = 1'b0; else v2 = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL beat_timeout: dut%0d never ready within %0d cycles", u, n);
    end
  endtask

  task automatic send_word(input int u, input logic [3:0][33:0] b, input int gap);
    for (int j = 0; j < 4; j++) begin
      send(u, b[j]);
      idle(gap < 0 ? int'($urandom_range(0, 2)) : gap);
    end
  endtask

  task automatic check_writes(input int u, input string nm);
    wr_t e, c;
    if (u == 0) begin
      chk({nm, "_count"}, 64'(cap1.size()), 64'(exp1.size()));
      while (exp1.size() > 0 && cap1.size() > 0) begin
        e = exp1.pop_front(); c = cap1.pop_front();
        chk({nm, "_addr"}, 64'(c.a), 64'(e.a));
        chk({nm, "_din"}, c.d, e.d);
      end
      exp1.delete(); cap1.delete();
    end else begin
      chk({nm, "_count"}, 64'(cap2.size()), 64'(exp2.size()));
      while (exp2.size() > 0 && cap2.size() > 0) begin
        e = exp2.pop_front(); c = cap2.pop_front();
        chk({nm, "_addr"}, 64'(c.a), 64'(e.a));
        chk({nm, "_din"}, c.d, e.d);
      end
      exp2.delete(); cap2.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t             tbl[4];
    logic [3:0][33:0] b;

    tbl[0].b = {34'h400, 34'h300, 34'h200, 34'h100};
    tbl[0].exp = 64'h0004_0003_0002_0001;
    tbl[1].b = {34'h0, 34'h7F_FF00, 34'h3_FF00_0000, 34'h0_0100_0000};
    tbl[2].b = {34'h0, 34'h0, 34'h0, 34'h3_FFFF_FF00};
    tbl[3].b = {34'h0_0080_0000, 34'h0_0000_00FF, 34'h3_FFFF_FFFF, 34'h3_FF80_0000};
`ifdef OFM_RELU_EN
    tbl[1].exp = 64'h0000_7FFF_0000_7FFF;
    tbl[2].exp = 64'h0000_0000_0000_0000;
    tbl[3].exp = 64'h7FFF_0000_0000_0000;
`else
    tbl[1].exp = 64'h0000_7FFF_8000_7FFF;
    tbl[2].exp = 64'h0000_0000_0000_FFFF;
    tbl[3].exp = 64'h7FFF_0000_FFFF_8000;
`endif

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", 64'(r1), 64'(0));
    chk("rst_en", 64'(en1), 64'(0));
    chk("rst_we", 64'(we1), 64'(0));
    chk("rst_addr", 64'(a1), 64'(0));
    chk("rst_din", o1, 64'(0));
    chk("rst_busy", 64'(busy1), 64'(0));
    chk("rst_done", 64'(done1), 64'(0));
    chk("rst_ww", 64'(ww1), 64'(0));
    chk("rst2_busy", 64'(busy2), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    chk("idle_ready", 64'(r1), 64'(0));

    // Frame A: constant vectors back-to-back, then random words with random gaps
    pulse_start(0);
    for (int i = 0; i < 4; i++) begin
      exp1.push_back('{a: 8'(i), d: tbl[i].exp});
      send_word(0, tbl[i].b, 0);
      if (i == 0) begin
        @(negedge clk);
        chk("latency_we", 64'(we1), 64'(1));
        chk("latency_addr", 64'(a1), 64'(0));
        chk("latency_din", o1, tbl[0].exp);
        @(posedge clk); #1;
      end
    end
    chk("busy_mid", 64'(busy1), 64'(1));
    for (int w = 4; w < 16; w++) begin
      for (int j = 0; j < 4; j++) b[j] = rnd34();
      exp1.push_back('{a: 8'(w), d: mword(b)});
      send_word(0, b, -1);
    end
    idle(4);
    check_writes(0, "frameA");
    chk("frameA_done_cnt", 64'(done_cnt1), 64'(1));
    chk("frameA_ww", 64'(ww1), 64'(16));
    chk("frameA_busy", 64'(busy1), 64'(0));

    // Frame B: valid toggled with one idle cycle after each beat
    pulse_start(0);
    for (int w = 0; w < 16; w++) begin
      for (int j = 0; j < 4; j++) b[j] = rnd34();
      exp1.push_back('{a: 8'(w), d: mword(b)});
      send_word(0, b, 1);
    end
    idle(4);
    check_writes(0, "frameB");
    chk("frameB_done_cnt", 64'(done_cnt1), 64'(2));
    chk("frameB_ww", 64'(ww1), 64'(16));
    chk("frameB_busy", 64'(busy1), 64'(0));

    // Frame C: address wrap from 0xFE, start pulse mid-frame is ignored
    pulse_start(1);
    for (int w = 0; w < 4; w++) begin
      if (w == 2) begin
        idle(1);
        pulse_start(1);
        chk("wrap_busy_mid", 64'(busy2), 64'(1));
      end
      for (int j = 0; j < 4; j++) b[j] = rnd34();
      exp2.push_back('{a: 8'(8'hFE + 8'(w)), d: mword(b)});
      send_word(1, b, -1);
    end
    idle(4);
    check_writes(1, "wrap");
    chk("wrap_done_cnt", 64'(done_cnt2), 64'(1));
    chk("wrap_ww", 64'(ww2), 64'(4));

    // Reset mid-word: outputs clear at once, partial word never written
    pulse_start(0);
    send(0, 34'h7700);
    send(0, 34'h8800);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(r1), 64'(0));
    chk("midrst_we", 64'(we1), 64'(0));
    chk("midrst_en", 64'(en1), 64'(0));
    chk("midrst_addr", 64'(a1), 64'(0));
    chk("midrst_din", o1, 64'(0));
    chk("midrst_busy", 64'(busy1), 64'(0));
    chk("midrst_ww", 64'(ww1), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    chk("midrst_no_write", 64'(cap1.size()), 64'(0));
    pulse_start(0);
    b = {34'h800, 34'h700, 34'h600, 34'h500};
    exp1.push_back('{a: 8'h00, d: 64'h0008_0007_0006_0005});
    send_word(0, b, 0);
    idle(2);
    check_writes(0, "postrst");
    chk("postrst_ww", 64'(ww1), 64'(1));

    chk("ready_during_write", 64'(rv1 + rv2), 64'(0));
    chk("en_eq_we", 64'(env1 + env2), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
